// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : program-counter owner; fetches one instruction per handshake
//               and steers the next PC from the decoder's select inputs.
// Revision    : 1.0
// ============================================================================
module instr_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_gnt,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [4:0]         opcode,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus2,
  input  logic [1:0]         pc_src,
  input  logic [ADDR_W-1:0]  br_offset,
  input  logic [ADDR_W-1:0]  rind_addr,
  output logic               misalign
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_instr;
  logic                r_valid;
  logic                r_mem_rd;
  logic                r_misalign;
  logic [ADDR_W-1:0]   w_pc_plus2;
  logic [ADDR_W-1:0]   w_nxt;

  assign w_pc_plus2 = r_pc + ADDR_W'(2);

  always_comb begin
    case (pc_src)
      2'b00:   w_nxt = r_pc + br_offset;
      2'b01:   w_nxt = rind_addr;
      default: w_nxt = w_pc_plus2;
    endcase
  end

  // The request flag lags reset release by one edge so mem_rd never rises
  // while reset is asserted and a grant is only honoured against a real request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (r_mem_rd && mem_gnt) begin
            r_mem_rd <= 1'b0;
            r_state  <= S_WAIT;
          end else begin
            r_mem_rd <= 1'b1;
          end
        end
        S_WAIT: begin
          r_instr <= mem_rdata;
          r_valid <= 1'b1;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (instr_ready) begin
            r_valid <= 1'b0;
            if (w_nxt[0]) begin
              r_misalign <= 1'b1;
              r_state    <= S_HALT;
            end else begin
              r_pc     <= w_nxt;
              r_mem_rd <= 1'b1;
              r_state  <= S_FETCH;
            end
          end
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_pc;
  assign pc          = r_pc;
  assign pc_plus2    = w_pc_plus2;
  assign instr       = r_instr;
  assign opcode      = r_instr[4:0];
  assign instr_valid = r_valid;
  assign misalign    = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch : scoreboard bench for instr_fetch with a one-cycle memory.
// Revision       : 1.0
// ============================================================================
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [4:0]  opcode;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic [1:0]  pc_src;
  logic [15:0] br_offset;
  logic [15:0] rind_addr;
  logic        misalign;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_pc;
  logic [31:0] sb[$];

  instr_fetch #(
    .ADDR_W  (16),
    .INSTR_W (16),
    .RESET_PC(16'h0000)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rdata  (mem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .opcode     (opcode),
    .pc         (pc),
    .pc_plus2   (pc_plus2),
    .pc_src     (pc_src),
    .br_offset  (br_offset),
    .rind_addr  (rind_addr),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a * 16'd37 + 16'd1;
  endfunction

  // Data is only meaningful the cycle after a granted request; otherwise junk.
  always @(posedge clk) begin
    mem_rdata <= (mem_rd && mem_gnt) ? mem_word(mem_addr) : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic junk_inputs();
    pc_src    = 2'($urandom);
    br_offset = 16'($urandom) | 16'h0001;
    rind_addr = 16'($urandom) | 16'h0001;
  endtask

  task automatic check_reset();
    check("rst_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_vld", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", {16'd0, instr}, 32'd0);
    check("rst_pc", {16'd0, pc}, 32'd0);
    check("rst_mis", {31'd0, misalign}, 32'd0);
  endtask

  // Entered at a negedge in FETCH with the request up; leaves at the negedge after accept.
  task automatic fetch_one(input int stall, input int hold, input logic [1:0] src,
                           input logic [15:0] off, input logic [15:0] rind);
    logic [31:0] e;
    logic [15:0] epc, ep2, nxt;
    check("req_rd", {31'd0, mem_rd}, 32'd1);
    check("req_addr", {16'd0, mem_addr}, {16'd0, exp_pc});
    mem_gnt = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_rd", {31'd0, mem_rd}, 32'd1);
      check("stall_addr", {16'd0, mem_addr}, {16'd0, exp_pc});
      check("stall_vld", {31'd0, instr_valid}, 32'd0);
    end
    mem_gnt = 1'b1;
    sb.push_back({exp_pc, mem_word(exp_pc)});
    @(negedge clk);
    mem_gnt = 1'b0;
    check("wait_rd", {31'd0, mem_rd}, 32'd0);
    check("wait_vld", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    check("hold_vld", {31'd0, instr_valid}, 32'd1);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    epc = e[31:16];
    ep2 = epc + 16'd2;
    check("instr", {16'd0, instr}, {16'd0, e[15:0]});
    check("opcode", {27'd0, opcode}, {27'd0, e[4:0]});
    check("pc", {16'd0, pc}, {16'd0, epc});
    check("pc_plus2", {16'd0, pc_plus2}, {16'd0, ep2});
    for (int i = 0; i < hold; i++) begin
      instr_ready = 1'b0;
      junk_inputs();
      @(negedge clk);
      check("bp_vld", {31'd0, instr_valid}, 32'd1);
      check("bp_instr", {16'd0, instr}, {16'd0, e[15:0]});
      check("bp_pc", {16'd0, pc}, {16'd0, epc});
      check("bp_rd", {31'd0, mem_rd}, 32'd0);
    end
    instr_ready = 1'b1;
    pc_src      = src;
    br_offset   = off;
    rind_addr   = rind;
    case (src)
      2'b00:   nxt = epc + off;
      2'b01:   nxt = rind;
      default: nxt = epc + 16'd2;
    endcase
    @(negedge clk);
    instr_ready = 1'b0;
    junk_inputs();
    check("acc_vld", {31'd0, instr_valid}, 32'd0);
    if (nxt[0]) begin
      check("mis_set", {31'd0, misalign}, 32'd1);
      check("mis_pc", {16'd0, pc}, {16'd0, epc});
      mem_gnt     = 1'b1;
      instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("halt_rd", {31'd0, mem_rd}, 32'd0);
        check("halt_vld", {31'd0, instr_valid}, 32'd0);
        check("halt_mis", {31'd0, misalign}, 32'd1);
        check("halt_pc", {16'd0, pc}, {16'd0, epc});
      end
      mem_gnt     = 1'b0;
      instr_ready = 1'b0;
    end else begin
      check("acc_pc", {16'd0, pc}, {16'd0, nxt});
      check("acc_mis", {31'd0, misalign}, 32'd0);
      exp_pc = nxt;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    mem_gnt     = 1'b0;
    instr_ready = 1'b0;
    pc_src      = 2'b10;
    br_offset   = '0;
    rind_addr   = '0;
    exp_pc      = 16'h0000;
    repeat (2) @(negedge clk);
    check_reset();
    reset_n = 1'b1;
    mem_gnt = 1'b1;
    @(negedge clk);

    fetch_one(0, 0, 2'b10, 16'h0000, 16'h0000);
    fetch_one(3, 0, 2'b10, 16'h0000, 16'h0000);
    fetch_one(0, 0, 2'b00, 16'h000C, 16'h0000);
    fetch_one(0, 0, 2'b00, 16'hFFF8, 16'h0000);
    fetch_one(0, 5, 2'b01, 16'h0000, 16'h0100);
    fetch_one(1, 0, 2'b11, 16'h0000, 16'h0000);
    fetch_one(0, 0, 2'b01, 16'h0000, 16'hFFFE);
    fetch_one(0, 0, 2'b10, 16'h0000, 16'h0000);
    fetch_one(0, 2, 2'b01, 16'h0000, 16'h0101);

    reset_n = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    reset_n = 1'b1;
    exp_pc  = 16'h0000;
    @(negedge clk);
    check("rr_rd", {31'd0, mem_rd}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    check("rw_vld", {31'd0, instr_valid}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rw_vld2", {31'd0, instr_valid}, 32'd0);
    fetch_one(0, 0, 2'b10, 16'h0000, 16'h0000);
    fetch_one(0, 0, 2'b10, 16'h0000, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
